// File: rtl/arb_pkg.sv
// Shared constants and helpers for the round-robin arbiter slice.
`timescale 1ns/1ps

package arb_pkg;

    localparam int unsigned IDX_W   = 2;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned HOLD_W  = 8;

    // FSM state encoding
    localparam logic IDLE  = 1'b0;
    localparam logic GRANT = 1'b1;

    // One-hot vector with only bit idx set
    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first eligible request after `last`, wrapping.
`timescale 1ns/1ps

module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   winner,
    output logic               found
);

    logic [NUM_REQ-1:0] eligible;

    assign eligible = req & ~mask;

    // Scan farthest-to-nearest so the nearest eligible index after `last` wins
    always_comb begin
        logic [IDX_W-1:0] idx;
        winner = last;
        found  = 1'b0;
        idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDX_W'(last + IDX_W'(k));
            if (eligible[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with bounded tenure, driving a 2x4 decoder select.
`timescale 1ns/1ps

module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic               i1,
    output logic               i2,
    output logic               gnt_valid
);

    // Tenure limit disabled when MAX_HOLD is zero
    localparam logic              HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    logic              state_q, state_d;
    logic [IDX_W-1:0]  g_q, g_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              valid_d;

    logic               held_c;
    logic               others_c;
    logic               expired_c;
    logic               force_rot_c;
    logic               load_c;
    logic [NUM_REQ-1:0] pick_mask;
    logic [IDX_W-1:0]   pick_win;
    logic               pick_found;

    // Decode the current grant situation and choose the picker mask
    always_comb begin
        held_c      = req[g_q];
        others_c    = |(req & ~idx_onehot(g_q));
        expired_c   = HOLD_EN && (cnt_q == HOLD_LAST);
        force_rot_c = (state_q == GRANT) && held_c && expired_c && others_c;
        pick_mask   = force_rot_c ? idx_onehot(g_q) : '0;
    end

    rr_pick4 u_pick (
        .req    (req),
        .mask   (pick_mask),
        .last   (last_q),
        .winner (pick_win),
        .found  (pick_found)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found) state_d = GRANT;
            GRANT:   if (!held_c && !pick_found) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next grant index, pointer, tenure counter and valid
    always_comb begin
        g_d     = g_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        valid_d = (state_d == GRANT);
        load_c  = ((state_q == IDLE) && pick_found)
                || ((state_q == GRANT) && !held_c && pick_found)
                || force_rot_c;
        if (load_c) begin
            g_d    = pick_win;
            last_d = pick_win;
            cnt_d  = '0;
        end else if ((state_q == GRANT) && held_c) begin
            if (!HOLD_EN || expired_c) begin
                cnt_d = '0;
            end else begin
                cnt_d = HOLD_W'(cnt_q + 1'b1);
            end
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q       <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            cnt_q     <= '0;
            gnt_valid <= 1'b0;
        end else begin
            g_q       <= g_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            gnt_valid <= valid_d;
        end
    end

    assign i1 = g_q[1];
    assign i2 = g_q[0];

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: one instance with MAX_HOLD=8, one with MAX_HOLD=0.
`timescale 1ns/1ps

module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst8_n, rst0_n;
    logic [3:0] req8, req0;
    logic       i1_8, i2_8, v8;
    logic       i1_0, i2_0, v0;

    always #5 clk = ~clk;

    rr_arbiter4 #(.MAX_HOLD(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst8_n),
        .req       (req8),
        .i1        (i1_8),
        .i2        (i2_8),
        .gnt_valid (v8)
    );

    rr_arbiter4 #(.MAX_HOLD(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst0_n),
        .req       (req0),
        .i1        (i1_0),
        .i2        (i2_0),
        .gnt_valid (v0)
    );

    typedef struct {
        bit         sel;
        logic       v;
        logic [1:0] g;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    event async_chk;

    // Drive one cycle of stimulus at the falling edge and queue the response expected after the next rising edge
    task automatic step(input bit sel, input logic rn, input logic [3:0] r,
                        input logic ev, input logic [1:0] eg, input string nm);
        exp_t e;
        @(negedge clk);
        if (sel) begin
            rst0_n = rn;
            req0   = r;
        end else begin
            rst8_n = rn;
            req8   = r;
        end
        e.sel  = sel;
        e.v    = ev;
        e.g    = eg;
        e.name = nm;
        sbq.push_back(e);
    endtask

    // Monitor: compare outputs after each rising edge (or an async-reset probe) against the queue head
    always begin : monitor
        exp_t       e;
        logic       av;
        logic [1:0] ag;
        @(posedge clk or async_chk);
        #1;
        if (sbq.size() > 0) begin
            e  = sbq.pop_front();
            av = e.sel ? v0 : v8;
            ag = e.sel ? {i1_0, i2_0} : {i1_8, i2_8};
            checks++;
            if (av !== e.v || ag !== e.g) begin
                errors++;
                $display("FAIL %s @%0t: got valid=%0b g=%0d, want valid=%0b g=%0d",
                         e.name, $time, av, ag, e.v, e.g);
            end
        end
    end

    initial begin
        exp_t e;
        rst8_n = 1'b0;
        rst0_n = 1'b0;
        req8   = 4'b0000;
        req0   = 4'b0000;

        // Reset state of both instances
        step(0, 1'b0, 4'b0000, 1'b0, 2'd0, "reset8");
        step(1, 1'b0, 4'b0000, 1'b0, 2'd0, "reset0");
        step(1, 1'b1, 4'b0000, 1'b0, 2'd0, "idle0");

        // No requests: stay idle with index 0
        for (int i = 0; i < 5; i++) step(0, 1'b1, 4'b0000, 1'b0, 2'd0, "idle8");

        // First grant from index 0 search, then release handoff without a bubble
        step(0, 1'b1, 4'b1010, 1'b1, 2'd1, "first_grant");
        step(0, 1'b1, 4'b1000, 1'b1, 2'd3, "handoff");
        step(0, 1'b1, 4'b0000, 1'b0, 2'd3, "release_idle");

        // Full contention: each index held exactly 8 cycles, rotating 0,1,2,3,0
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 8; j++)
                step(0, 1'b1, 4'b1111, 1'b1, 2'(k), "rotate");
        step(0, 1'b1, 4'b1111, 1'b1, 2'd0, "rotate_wrap");
        step(0, 1'b1, 4'b0000, 1'b0, 2'd0, "rotate_idle");

        // Lone requester past the tenure limit: no rotation, no bubble
        for (int i = 0; i < 30; i++) step(0, 1'b1, 4'b0100, 1'b1, 2'd2, "solo");

        // Asynchronous reset mid-grant, probed before any clock edge
        @(negedge clk);
        rst8_n = 1'b0;
        req8   = 4'b1100;
        e.sel  = 1'b0;
        e.v    = 1'b0;
        e.g    = 2'd0;
        e.name = "async_rst";
        sbq.push_back(e);
        -> async_chk;
        step(0, 1'b0, 4'b1100, 1'b0, 2'd0, "in_reset");
        step(0, 1'b1, 4'b1100, 1'b1, 2'd2, "post_reset");
        for (int j = 0; j < 7; j++) step(0, 1'b1, 4'b1100, 1'b1, 2'd2, "post_reset_hold");
        step(0, 1'b1, 4'b1100, 1'b1, 2'd3, "post_reset_rot");

        // Unlimited tenure: hold index 0 until it drops, then hand to 1
        step(1, 1'b1, 4'b0011, 1'b1, 2'd0, "unl_first");
        for (int i = 0; i < 20; i++) step(1, 1'b1, 4'b0011, 1'b1, 2'd0, "unl_hold");
        step(1, 1'b1, 4'b0010, 1'b1, 2'd1, "unl_handoff");
        step(1, 1'b1, 4'b0000, 1'b0, 2'd1, "unl_idle");

        // Let the monitor drain the queue
        repeat (3) @(negedge clk);
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
